// File: rtl/uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// uart_tx_arbiter
//
// Purpose:
//   Shares one UART transmitter between up to four byte requesters. A
//   round-robin arbiter picks one requester while the transmitter is idle,
//   takes its byte, and hands it to the transmitter as a single frame. It
//   then waits for the transmitter's done flag to rise and fall before it
//   arbitrates again.
//
// Build option:
//   UART_TX_ARB_TAG_EN - when defined, each grant is sent as two frames. The
//                        first frame is a tag byte (TAG_BASE | index) and the
//                        second is the data byte. When undefined, the tag
//                        states are not built and each grant is one frame.
//
// Parameters:
//   NUM_REQ      number of requesters, 2..4
//   TAG_BASE     tag byte base value; its low two bits must be zero
//
// Ports:
//   i_Clock      single rising-edge clock
//   i_Rst_n      synchronous active-low reset
//   i_Req_Valid  per-requester "byte pending" flags
//   i_Req_Byte   requester k's byte at [8k+7:8k]
//   o_Req_Ready  one-hot accept strobe, combinational, only in the grant cycle
//   o_Tx_DV      one-cycle start strobe to the transmitter
//   o_Tx_Byte    byte presented to the transmitter
//   i_Tx_Active  transmitter frame-in-progress flag
//   i_Tx_Done    transmitter done flag, high for two cycles per frame
//   o_Grant_Idx  index of the requester being served, held until next grant
//   o_Busy       high whenever the arbiter is not idle
// ---------------------------------------------------------------------------
module uart_tx_arbiter #(
  parameter int         NUM_REQ  = 4,
  parameter logic [7:0] TAG_BASE = 8'hA0
) (
  input  logic                 i_Clock,
  input  logic                 i_Rst_n,
  input  logic [NUM_REQ-1:0]   i_Req_Valid,
  input  logic [8*NUM_REQ-1:0] i_Req_Byte,
  output logic [NUM_REQ-1:0]   o_Req_Ready,
  output logic                 o_Tx_DV,
  output logic [7:0]           o_Tx_Byte,
  input  logic                 i_Tx_Active,
  input  logic                 i_Tx_Done,
  output logic [1:0]           o_Grant_Idx,
  output logic                 o_Busy
);

`ifdef UART_TX_ARB_TAG_EN
  typedef enum logic [2:0] {
    IDLE,
    SEND_TAG,
    WAIT_TAG,
    DRAIN_TAG,
    SEND_DATA,
    WAIT_DATA,
    DRAIN_DATA
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE,
    SEND_DATA,
    WAIT_DATA,
    DRAIN_DATA
  } state_t;
`endif

  state_t      state;
  state_t      state_next;
  logic [1:0]  last_grant;
  logic [1:0]  grant_idx;
  logic [7:0]  data_byte;
  logic        win_found;
  logic [1:0]  win_idx;
  logic [7:0]  win_byte;
  logic        grant;
  logic [7:0]  tag_byte;

  // Round-robin search: start one past the last winner and wrap, so the
  // most recently served requester has the lowest priority.
  always_comb begin
    int cand;
    cand      = 0;
    win_found = 1'b0;
    win_idx   = 2'd0;
    win_byte  = 8'h00;
    for (int off = 1; off <= NUM_REQ; off++) begin
      cand = (int'(last_grant) + off) % NUM_REQ;
      if (!win_found && i_Req_Valid[cand]) begin
        win_found = 1'b1;
        win_idx   = 2'(cand);
        win_byte  = i_Req_Byte[cand*8 +: 8];
      end
    end
  end

  // A grant happens only in IDLE with the transmitter fully quiet. Gating
  // with reset keeps a requester from handing over a byte that reset would
  // then throw away.
  assign grant = i_Rst_n && (state == IDLE) && !i_Tx_Active && !i_Tx_Done
                 && win_found;

  // The accept strobe goes only to the winner, and only in the grant cycle.
  always_comb begin
    o_Req_Ready = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      o_Req_Ready[k] = grant && (win_idx == 2'(k));
    end
  end

  assign tag_byte    = TAG_BASE | {6'b000000, grant_idx};
  assign o_Grant_Idx = grant_idx;

  // State register and grant capture. last_grant resets to the top index so
  // that requester 0 wins the first round after reset.
  always_ff @(posedge i_Clock) begin
    if (!i_Rst_n) begin
      state      <= IDLE;
      last_grant <= 2'(NUM_REQ - 1);
      grant_idx  <= 2'd0;
      data_byte  <= 8'h00;
    end else begin
      state <= state_next;
      if (grant) begin
        last_grant <= win_idx;
        grant_idx  <= win_idx;
        data_byte  <= win_byte;
      end
    end
  end

  // Next-state and output decode. The transmitter ignores o_Tx_Byte except
  // while o_Tx_DV is high, so outside SEND_DATA it simply shows the tag.
  // Each frame waits for Done to rise and then fall. This keeps a two-cycle
  // Done pulse from being counted twice.
  always_comb begin
    state_next = state;
    o_Tx_DV    = 1'b0;
    o_Tx_Byte  = tag_byte;
    o_Busy     = (state != IDLE);
    case (state)
      IDLE: begin
        if (grant) begin
`ifdef UART_TX_ARB_TAG_EN
          state_next = SEND_TAG;
`else
          state_next = SEND_DATA;
`endif
        end
      end
`ifdef UART_TX_ARB_TAG_EN
      SEND_TAG: begin
        o_Tx_DV    = 1'b1;
        o_Tx_Byte  = tag_byte;
        state_next = WAIT_TAG;
      end
      WAIT_TAG: begin
        if (i_Tx_Done) state_next = DRAIN_TAG;
      end
      DRAIN_TAG: begin
        if (!i_Tx_Done) state_next = SEND_DATA;
      end
`endif
      SEND_DATA: begin
        o_Tx_DV    = 1'b1;
        o_Tx_Byte  = data_byte;
        state_next = WAIT_DATA;
      end
      WAIT_DATA: begin
        if (i_Tx_Done) state_next = DRAIN_DATA;
      end
      DRAIN_DATA: begin
        if (!i_Tx_Done) state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_arbiter
//
// Directed bench for uart_tx_arbiter. The arbiter drives a behavioural UART
// transmitter with four clocks per bit. A small serial decoder reads the
// line back, so the bytes that actually appear on the wire can be compared
// with the hand-computed values.
// ---------------------------------------------------------------------------
module tb_uart_tx_arbiter;

  logic        clock = 1'b0;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [31:0] req_byte;
  logic [3:0]  req_ready;
  logic        tx_dv;
  logic [7:0]  tx_byte;
  logic        tx_active = 1'b0;
  logic        tx_done   = 1'b0;
  logic        tx_serial = 1'b1;
  logic [1:0]  grant_idx;
  logic        busy;

  int assert_count = 0;
  int fail_count   = 0;

  always #5 clock = ~clock;

  uart_tx_arbiter #(
    .NUM_REQ  (4),
    .TAG_BASE (8'hA0)
  ) dut (
    .i_Clock     (clock),
    .i_Rst_n     (rst_n),
    .i_Req_Valid (req_valid),
    .i_Req_Byte  (req_byte),
    .o_Req_Ready (req_ready),
    .o_Tx_DV     (tx_dv),
    .o_Tx_Byte   (tx_byte),
    .i_Tx_Active (tx_active),
    .i_Tx_Done   (tx_done),
    .o_Grant_Idx (grant_idx),
    .o_Busy      (busy)
  );

  // Behavioural transmitter: 10 bits of 4 clocks each, then Done for 2 clocks.
  int         tx_phase   = 0;
  int         tx_bit     = 0;
  int         tx_cnt     = 0;
  int         done_cnt   = 0;
  int         dv_total   = 0;
  int         dv_overlap = 0;
  logic [9:0] tx_frame   = '1;

  always @(posedge clock) begin
    if (tx_dv) begin
      dv_total <= dv_total + 1;
      if (tx_phase != 0) dv_overlap <= dv_overlap + 1;
    end
    case (tx_phase)
      0: begin
        if (tx_dv) begin
          tx_frame  <= {1'b1, tx_byte, 1'b0};
          tx_serial <= 1'b0;
          tx_active <= 1'b1;
          tx_bit    <= 0;
          tx_cnt    <= 0;
          tx_phase  <= 1;
        end
      end
      1: begin
        if (tx_cnt == 3) begin
          tx_cnt <= 0;
          if (tx_bit == 9) begin
            tx_serial <= 1'b1;
            tx_active <= 1'b0;
            tx_done   <= 1'b1;
            done_cnt  <= 0;
            tx_phase  <= 2;
          end else begin
            tx_bit    <= tx_bit + 1;
            tx_serial <= tx_frame[tx_bit + 1];
          end
        end else begin
          tx_cnt <= tx_cnt + 1;
        end
      end
      default: begin
        if (done_cnt == 1) begin
          tx_done  <= 1'b0;
          tx_phase <= 0;
        end else begin
          done_cnt <= done_cnt + 1;
        end
      end
    endcase
  end

  // Serial decoder: finds the start bit, samples each data bit in the middle
  // of its bit time, and queues the byte it reads.
  int         rx_phase = 0;
  int         rx_cnt   = 0;
  logic [7:0] rx_shift = 8'h00;
  logic [7:0] rx_q[$];

  always @(posedge clock) begin
    if (rx_phase == 0) begin
      if (tx_serial == 1'b0) begin
        rx_phase <= 1;
        rx_cnt   <= 1;
      end
    end else begin
      rx_cnt <= rx_cnt + 1;
      if (rx_cnt >= 5 && rx_cnt <= 33 && ((rx_cnt - 5) % 4) == 0)
        rx_shift <= {tx_serial, rx_shift[7:1]};
      if (rx_cnt == 37) begin
        rx_q.push_back(rx_shift);
        rx_phase <= 0;
      end
    end
  end

  // Mid-cycle monitor: counts ready pulses per requester, and counts any
  // grant made while the transmitter is still active or done.
  int ready_pulses[4] = '{default: 0};
  int bad_grant       = 0;

  always begin
    @(negedge clock);
    #2;
    for (int k = 0; k < 4; k++)
      if (req_ready[k]) ready_pulses[k] <= ready_pulses[k] + 1;
    if ((|req_ready) && (tx_active || tx_done)) bad_grant <= bad_grant + 1;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic stepCycle();
    @(negedge clock);
    #1;
  endtask

  task automatic applyStimulus(input logic [3:0] valid, input logic [31:0] bytes);
    req_valid = valid;
    req_byte  = bytes;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    assert_count++;
    assert (observed === expected) else begin
      fail_count++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic waitDv(input string tag, input int budget);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (tx_dv === 1'b1) begin
        ok = 1'b1;
        break;
      end
      stepCycle();
    end
    checkOutput(tag, 32'(ok), 32'd1);
  endtask

  task automatic waitIdle(input string tag, input int budget, output bit saw_done);
    bit ok;
    ok       = 1'b0;
    saw_done = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (busy === 1'b0) begin
        ok = 1'b1;
        break;
      end
      if (tx_done === 1'b1) saw_done = 1'b1;
      stepCycle();
    end
    checkOutput(tag, 32'(ok), 32'd1);
  endtask

  initial begin
    bit saw_done;
    int dv_base;
    int rdy_base;
    int exp_order[5] = '{0, 1, 2, 3, 0};

    // Reset state.
    rst_n = 1'b0;
    applyStimulus(4'b0000, 32'h0);
    stepCycle();
    stepCycle();
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_dv", 32'(tx_dv), 32'd0);
    checkOutput("rst_ready", 32'(req_ready), 32'd0);
    checkOutput("rst_grant_idx", 32'(grant_idx), 32'd0);
    rst_n = 1'b1;
    stepCycle();

`ifdef UART_TX_ARB_TAG_EN
    // Requester 1 with 0x33: tag frame 0xA1, then data frame 0x33.
    dv_base  = dv_total;
    rdy_base = ready_pulses[1];
    rx_q.delete();
    applyStimulus(4'b0010, 32'h0000_3300);
    checkOutput("tag_ready", 32'(req_ready), 32'h2);
    stepCycle();
    applyStimulus(4'b0000, 32'h0);
    checkOutput("tag_dv1", 32'(tx_dv), 32'd1);
    checkOutput("tag_byte1", 32'(tx_byte), 32'hA1);
    checkOutput("tag_idx", 32'(grant_idx), 32'd1);
    stepCycle();
    checkOutput("tag_dv_one_cycle", 32'(tx_dv), 32'd0);
    waitDv("tag_dv2_timeout", 200);
    checkOutput("tag_byte2", 32'(tx_byte), 32'h33);
    waitIdle("tag_idle_timeout", 200, saw_done);
    checkOutput("tag_dv_count", 32'(dv_total - dv_base), 32'd2);
    checkOutput("tag_ready_pulses", 32'(ready_pulses[1] - rdy_base), 32'd1);
    checkOutput("tag_rx_count", 32'(rx_q.size()), 32'd2);
    checkOutput("tag_rx0", 32'(rx_q[0]), 32'hA1);
    checkOutput("tag_rx1", 32'(rx_q[1]), 32'h33);
`else
    // Requester 2 alone with 0x5A.
    dv_base  = dv_total;
    rdy_base = ready_pulses[2];
    rx_q.delete();
    applyStimulus(4'b0100, 32'h005A_0000);
    checkOutput("s1_ready", 32'(req_ready), 32'h4);
    checkOutput("s1_dv_not_yet", 32'(tx_dv), 32'd0);
    stepCycle();
    applyStimulus(4'b0000, 32'h0);
    checkOutput("s1_dv", 32'(tx_dv), 32'd1);
    checkOutput("s1_byte", 32'(tx_byte), 32'h5A);
    checkOutput("s1_grant_idx", 32'(grant_idx), 32'd2);
    checkOutput("s1_busy", 32'(busy), 32'd1);
    checkOutput("s1_ready_cleared", 32'(req_ready), 32'd0);
    stepCycle();
    checkOutput("s1_dv_one_cycle", 32'(tx_dv), 32'd0);
    waitIdle("s1_idle_timeout", 200, saw_done);
    checkOutput("s1_busy_through_done", 32'(saw_done), 32'd1);
    checkOutput("s1_done_low_at_idle", 32'(tx_done), 32'd0);
    checkOutput("s1_grant_idx_held", 32'(grant_idx), 32'd2);
    checkOutput("s1_dv_count", 32'(dv_total - dv_base), 32'd1);
    checkOutput("s1_ready_pulses", 32'(ready_pulses[2] - rdy_base), 32'd1);
    checkOutput("s1_rx_count", 32'(rx_q.size()), 32'd1);
    checkOutput("s1_rx_byte", 32'(rx_q[0]), 32'h5A);

    // All four requesters held from reset: order 0,1,2,3,0.
    rst_n = 1'b0;
    applyStimulus(4'b1111, 32'h1312_1110);
    checkOutput("s2_ready_in_reset", 32'(req_ready), 32'd0);
    stepCycle();
    rst_n = 1'b1;
    #1;
    dv_base = dv_total;
    rx_q.delete();
    checkOutput("s2_first_ready", 32'(req_ready), 32'h1);
    for (int f = 0; f < 5; f++) begin
      waitDv($sformatf("s2_dv_timeout_%0d", f), 200);
      checkOutput($sformatf("s2_idx_%0d", f), 32'(grant_idx), 32'(exp_order[f]));
      checkOutput($sformatf("s2_byte_%0d", f), 32'(tx_byte), 32'h10 + 32'(exp_order[f]));
      if (f == 4) applyStimulus(4'b0000, 32'h0);
      stepCycle();
      checkOutput($sformatf("s2_dv_one_cycle_%0d", f), 32'(tx_dv), 32'd0);
    end
    waitIdle("s2_idle_timeout", 200, saw_done);
    checkOutput("s2_dv_count", 32'(dv_total - dv_base), 32'd5);
    checkOutput("s2_dv_overlap", 32'(dv_overlap), 32'd0);
    checkOutput("s2_rx_count", 32'(rx_q.size()), 32'd5);
    for (int f = 0; f < 5; f++)
      checkOutput($sformatf("s2_rx_%0d", f), 32'(rx_q[f]), 32'h10 + 32'(exp_order[f]));

    // Reset in the middle of a data frame, with requester 0 still valid.
    rx_q.delete();
    applyStimulus(4'b0001, 32'h0000_00C3);
    waitDv("s3_dv1_timeout", 200);
    checkOutput("s3_byte1", 32'(tx_byte), 32'hC3);
    for (int i = 0; i < 6; i++) stepCycle();
    checkOutput("s3_midframe_active", 32'(tx_active), 32'd1);
    checkOutput("s3_midframe_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    stepCycle();
    rst_n = 1'b1;
    #1;
    checkOutput("s3_busy_after_reset", 32'(busy), 32'd0);
    checkOutput("s3_ready_while_active", 32'(req_ready), 32'd0);
    dv_base = dv_total;
    waitDv("s3_dv2_timeout", 200);
    checkOutput("s3_no_dv_before_idle", 32'(dv_total - dv_base), 32'd0);
    checkOutput("s3_tx_quiet_at_dv", 32'({tx_active, tx_done}), 32'd0);
    checkOutput("s3_byte2", 32'(tx_byte), 32'hC3);
    checkOutput("s3_idx2", 32'(grant_idx), 32'd0);
    applyStimulus(4'b0000, 32'h0);
    waitIdle("s3_idle_timeout", 200, saw_done);
    checkOutput("s3_sent_once", 32'(dv_total - dv_base), 32'd1);
    checkOutput("s3_rx_count", 32'(rx_q.size()), 32'd2);

    // Requester 3 asserts valid in the cycle Done falls.
    applyStimulus(4'b0010, 32'h0000_7700);
    waitDv("s4_dv1_timeout", 200);
    checkOutput("s4_idx1", 32'(grant_idx), 32'd1);
    applyStimulus(4'b0000, 32'h0);
    for (int i = 0; i < 200 && tx_done !== 1'b1; i++) stepCycle();
    checkOutput("s4_done_seen", 32'(tx_done), 32'd1);
    for (int i = 0; i < 10 && tx_done !== 1'b0; i++) stepCycle();
    checkOutput("s4_done_fell", 32'(tx_done), 32'd0);
    applyStimulus(4'b1000, 32'h9E00_0000);
    checkOutput("s4_no_ready_in_drain", 32'(req_ready), 32'd0);
    checkOutput("s4_busy_in_drain", 32'(busy), 32'd1);
    stepCycle();
    checkOutput("s4_ready_next_idle", 32'(req_ready), 32'h8);
    stepCycle();
    applyStimulus(4'b0000, 32'h0);
    checkOutput("s4_dv", 32'(tx_dv), 32'd1);
    checkOutput("s4_idx2", 32'(grant_idx), 32'd3);
    checkOutput("s4_byte2", 32'(tx_byte), 32'h9E);
    waitIdle("s4_idle_timeout", 200, saw_done);
`endif

    checkOutput("no_grant_while_tx_busy", 32'(bad_grant), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             assert_count, fail_count);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 The module SHALL have parameter NUM_REQ, default 4, which sets the number of requesters (legal range 2..4).
REQ-002 The module SHALL have parameter TAG_BASE, default 8'hA0, which is the tag byte base (bits [1:0] SHALL be 0).
REQ-003 The module SHALL have port i_Clock, input, 1 bit: the single clock; all logic is rising-edge.
REQ-004 The module SHALL have port i_Rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-005 The module SHALL have port i_Req_Valid, input, NUM_REQ bits: bit k means requester k holds a byte to send.
REQ-006 The module SHALL have port i_Req_Byte, input, 8*NUM_REQ bits: requester k's byte is at [8k+7:8k].
REQ-007 The module SHALL have port o_Req_Ready, output, NUM_REQ bits: one-hot accept strobe.
REQ-008 The module SHALL have port o_Tx_DV, output, 1 bit: the one-cycle start strobe to the UART transmitter.
REQ-009 The module SHALL have port o_Tx_Byte, output, 8 bits: the byte presented to the transmitter.
REQ-010 The module SHALL have port i_Tx_Active, input, 1 bit: the transmitter's frame-in-progress flag.
REQ-011 The module SHALL have port i_Tx_Done, input, 1 bit: the transmitter's done flag, which is high for 2 cycles at the end of each frame.
REQ-012 The module SHALL have port o_Grant_Idx, output, 2 bits: the index of the requester being served.
REQ-013 The module SHALL have port o_Busy, output, 1 bit: high in every state except IDLE.

Function
REQ-014 The module SHALL implement the states IDLE, SEND_TAG, WAIT_TAG, DRAIN_TAG, SEND_DATA, WAIT_DATA and DRAIN_DATA.
REQ-015 The module SHALL grant in IDLE only when i_Tx_Active=0, i_Tx_Done=0 and at least one i_Req_Valid bit is 1.
REQ-016 Arbitration SHALL be round-robin: search from last_grant+1 upward, wrapping at NUM_REQ; the first valid requester found wins.
REQ-017 o_Req_Ready SHALL be combinational: only the winner's bit is high, and only during the grant cycle in IDLE.
REQ-018 On the grant edge, the module SHALL latch the winner's byte and index, update last_grant, and go to SEND_TAG (tag build) or SEND_DATA.
REQ-019 A requester SHALL hold its valid and byte stable until it sees its ready bit; the transfer occurs on the edge where valid&ready=1.
REQ-020 SEND_x states SHALL drive o_Tx_DV=1 for exactly one cycle, then move to WAIT_x.
REQ-021 WAIT_x SHALL move to DRAIN_x on i_Tx_Done=1.
REQ-022 DRAIN_x SHALL move on i_Tx_Done=0: DRAIN_TAG goes to SEND_DATA; DRAIN_DATA goes to IDLE.
REQ-023 o_Tx_Byte SHALL equal TAG_BASE|idx in SEND_TAG and the latched data byte in SEND_DATA; its value is don't-care elsewhere.
REQ-024 Latency: with valid in IDLE at cycle N, o_Tx_DV SHALL be high at cycle N+1.
REQ-025 o_Req_Ready SHALL be 0 in all non-IDLE states; valid changes during a frame SHALL have no effect until IDLE.
REQ-026 For back-to-back requests, the next grant SHALL occur no earlier than the first IDLE cycle after i_Tx_Done falls.
REQ-027 A requester with bit index >= NUM_REQ SHALL be ignored.
REQ-028 o_Grant_Idx SHALL hold the last granted index until the next grant.

Reset
REQ-029 When i_Rst_n=0 at a rising edge, the module SHALL set state=IDLE, o_Tx_DV=0, o_Req_Ready=0, o_Busy=0, o_Grant_Idx=0, last_grant=NUM_REQ-1 and the latched byte=0.
REQ-030 On reset mid-frame, no byte SHALL be re-sent.
REQ-031 After a mid-frame reset, the next grant SHALL wait until i_Tx_Active=0 and i_Tx_Done=0.

Configuration
REQ-032 When macro UART_TX_ARB_TAG_EN is defined, the module SHALL send each grant as two frames: the tag byte (TAG_BASE|idx), then the data byte.
REQ-033 When UART_TX_ARB_TAG_EN is undefined, the SEND_TAG, WAIT_TAG and DRAIN_TAG states SHALL not exist, and each grant SHALL be one data frame.

Verification
REQ-034 Bench setup: connect to the UART transmitter with CLKS_PER_BIT=4.
REQ-035 Scenario: only valid[2] with byte 8'h5A, tag off -> ready[2] pulses 1 cycle, o_Tx_DV high the next cycle, serial line carries 0x5A, o_Busy falls after Done drops.
REQ-036 Scenario: all four valids held from reset, tag off -> grant order 0,1,2,3,0; exactly one o_Tx_DV per frame.
REQ-037 Scenario: valid[1] with byte 8'h33, tag on -> two frames 0xA1 then 0x33, with a single ready[1] pulse.
REQ-038 Scenario: i_Rst_n low during WAIT_DATA, valid[0] held -> no DV until the transmitter returns idle, then byte 0 is sent once.
REQ-039 Scenario: valid[3] asserted in the same cycle i_Tx_Done falls -> grant on the following IDLE cycle, never while Done=1.
